// File: rtl/pipe_skid_stage_reg.sv
// Two-entry skid buffer between pipeline stages with freeze, flush and a bubble-safe control bundle.
// The head register drives the outputs; the skid register absorbs one extra entry while downstream stalls.
module pipe_skid_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_val_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] val_rm;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;
    entry_t head, head_n;
    entry_t skid, skid_n;
    entry_t in_entry;
    logic   push;
    logic   pop;

    assign in_entry = '{ctrl: in_ctrl, dest: in_dest, alu_res: in_alu_res, val_rm: in_val_rm};

    // Handshakes depend only on state and freeze, so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL) && !freeze;
    assign out_valid = (state != EMPTY) && !freeze;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_ctrl    = out_valid ? head.ctrl : '0;
    assign out_dest    = head.dest;
    assign out_alu_res = head.alu_res;
    assign out_val_rm  = head.val_rm;
    assign occupancy   = 2'(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_n;
            head  <= head_n;
            skid  <= skid_n;
        end
    end

    // Flush wins over freeze; push and pop already carry the freeze gating.
    always_comb begin
        state_n = state;
        head_n  = head;
        skid_n  = skid;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_n  = in_entry;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_n = in_entry;
                    end else if (push) begin
                        skid_n  = in_entry;
                        state_n = FULL;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_n  = skid;
                        state_n = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Bench for pipe_skid_stage_reg: directed scenarios plus a randomized run, checked through an ordered scoreboard.
module tb_pipe_skid_stage_reg;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] val;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_ctrl = '0;
    logic [3:0]  in_dest = '0;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_val_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_ctrl;
    logic [3:0]  out_dest;
    logic [31:0] out_alu_res;
    logic [31:0] out_val_rm;
    logic [1:0]  occupancy;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t sb[$];
    ent_t z = '0;

    pipe_skid_stage_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest), .in_alu_res(in_alu_res), .in_val_rm(in_val_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_dest(out_dest), .out_alu_res(out_alu_res), .out_val_rm(out_val_rm),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, required finish before 500000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [2:0] c, input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
        ent_t e;
        e.ctrl = c;
        e.dest = d;
        e.alu  = a;
        e.val  = v;
        return e;
    endfunction

    // Drive one cycle of inputs; a handshake the stage will honour queues its expected output.
    task automatic step(input logic iv, input ent_t e, input logic ordy, input logic frz, input logic fl);
        @(posedge clk);
        #1;
        in_valid   = iv;
        in_ctrl    = e.ctrl;
        in_dest    = e.dest;
        in_alu_res = e.alu;
        in_val_rm  = e.val;
        out_ready  = ordy;
        freeze     = frz;
        flush      = fl;
        @(negedge clk);
        if (fl || rst) sb.delete();
        else if (iv && in_ready) sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: every accepted head entry must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 72'(1), 72'(0));
                end else begin
                    check("out_entry", 72'({out_ctrl, out_dest, out_alu_res, out_val_rm}), 72'(sb.pop_front()));
                end
            end
            if (out_valid !== 1'b1) check("bubble_ctrl", 72'(out_ctrl), 72'(0));
        end
    end

    initial begin
        ent_t e;
        do_reset();

        step(1'b0, z, 1'b0, 1'b0, 1'b0);
        check("rst_occ", 72'(occupancy), 72'(0));
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_ctrl", 72'(out_ctrl), 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_payload", 72'({out_dest, out_alu_res, out_val_rm}), 72'(0));

        // Streaming with downstream always ready.
        step(1'b1, mk(3'b001, 4'hA, 32'h1234, 32'h0), 1'b1, 1'b0, 1'b0);
        check("stream_in_ready", 72'(in_ready), 72'(1));
        check("stream_first_empty", 72'(out_valid), 72'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk(3'(i), 4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i)), 1'b1, 1'b0, 1'b0);
            check("stream_occ", 72'(occupancy), 72'(1));
            check("stream_valid", 72'(out_valid), 72'(1));
            if (i == 0) check("stream_head_a", 72'({out_dest, out_alu_res}), 72'({4'hA, 32'h1234}));
        end
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("stream_drained", 72'(occupancy), 72'(0));

        // Fill while downstream stalls, then drain in order.
        step(1'b1, mk(3'b010, 4'h1, 32'hAAAA0001, 32'h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3'b100, 4'h2, 32'hBBBB0002, 32'h22), 1'b0, 1'b0, 1'b0);
        check("fill_one_ready", 72'(in_ready), 72'(1));
        step(1'b1, mk(3'b111, 4'hF, 32'hDEAD, 32'hBEEF), 1'b0, 1'b0, 1'b0);
        check("full_occ", 72'(occupancy), 72'(2));
        check("full_in_ready", 72'(in_ready), 72'(0));
        check("full_head_a", 72'(out_dest), 72'(4'h1));
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("drain_occ2", 72'(occupancy), 72'(2));
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("drain_occ1", 72'(occupancy), 72'(1));
        check("drain_head_b", 72'(out_dest), 72'(4'h2));
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("drain_occ0", 72'(occupancy), 72'(0));

        // Freeze while full holds everything and hides the head.
        step(1'b1, mk(3'b001, 4'h3, 32'h3333, 32'h3), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3'b010, 4'h4, 32'h4444, 32'h4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(3'b111, 4'h9, 32'h9999, 32'h9), 1'b1, 1'b1, 1'b0);
            check("frz_valid", 72'(out_valid), 72'(0));
            check("frz_ctrl", 72'(out_ctrl), 72'(0));
            check("frz_in_ready", 72'(in_ready), 72'(0));
            check("frz_occ", 72'(occupancy), 72'(2));
        end
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("unfrz_head_a", 72'({out_ctrl, out_dest}), 72'({3'b001, 4'h3}));
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("unfrz_head_b", 72'({out_ctrl, out_dest}), 72'({3'b010, 4'h4}));
        step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("unfrz_empty", 72'(occupancy), 72'(0));

        // Flush beats freeze and a pending push.
        step(1'b1, mk(3'b011, 4'h5, 32'h5555, 32'h5), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3'b101, 4'h6, 32'h6666, 32'h6), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3'b111, 4'h7, 32'h7777, 32'h7), 1'b1, 1'b1, 1'b1);
        step(1'b0, z, 1'b0, 1'b0, 1'b0);
        check("flush_occ", 72'(occupancy), 72'(0));
        check("flush_valid", 72'(out_valid), 72'(0));
        check("flush_ctrl", 72'(out_ctrl), 72'(0));
        check("flush_in_ready", 72'(in_ready), 72'(1));

        // Reset from ONE clears state and payload.
        step(1'b1, mk(3'b110, 4'hC, 32'hCAFE, 32'hF00D), 1'b0, 1'b0, 1'b0);
        step(1'b0, z, 1'b0, 1'b0, 1'b0);
        check("one_ctrl", 72'({occupancy, out_ctrl}), 72'({2'd1, 3'b110}));
        do_reset();
        step(1'b0, z, 1'b0, 1'b0, 1'b0);
        check("rst2_outputs", 72'({out_valid, out_ctrl, out_dest, out_alu_res, out_val_rm}), 72'(0));
        check("rst2_occ", 72'(occupancy), 72'(0));
        check("rst2_in_ready", 72'(in_ready), 72'(1));

        // Randomized push/pop/freeze/flush traffic.
        for (int i = 0; i < 400; i++) begin
            e = mk(3'(i), 4'(i), 32'(i) * 32'd3 + 32'd7, ~32'(i));
            step(1'($urandom_range(0, 1)), e, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, z, 1'b1, 1'b0, 1'b0);
        check("sb_drained", 72'(sb.size()), 72'(0));
        check("final_occ", 72'(occupancy), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage_reg.md
PIPE_SKID_STAGE_REG -- requirements
Module: pipe_skid_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of each data payload field (ALU result, store value).
REQ-002 Parameter DEST_W, default 4, width of the destination register index.
REQ-003 Parameter CTRL_W, default 3, width of the control-enable bundle {MEM_R_EN, MEM_W_EN, WB_EN}.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 freeze  in  1  stall request from hazard/memory unit; holds the whole stage.
REQ-007 flush  in  1  discard all held entries (branch taken / exception).
REQ-008 in_valid  in  1  upstream presents a valid entry.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  control enables of the incoming entry.
REQ-011 in_dest  in  DEST_W  destination register index.
REQ-012 in_alu_res  in  DATA_W  ALU result / memory address.
REQ-013 in_val_rm  in  DATA_W  store data value.
REQ-014 out_valid  out  1  head entry valid for downstream.
REQ-015 out_ready  in  1  downstream accepts head entry this cycle.
REQ-016 out_ctrl, out_dest, out_alu_res, out_val_rm  out  CTRL_W/DEST_W/DATA_W/DATA_W  head entry fields.
REQ-017 occupancy  out  2  number of held entries (0, 1 or 2).

Function
REQ-018 Storage SHALL be two entries: head register (drives outputs) and skid register; state EMPTY (0), ONE (1), FULL (2), reported on occupancy.
REQ-019 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-020 in_ready SHALL be 1 iff state != FULL and freeze = 0; no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL be 1 iff state != EMPTY and freeze = 0.
REQ-022 out_ctrl SHALL be forced to all-zero whenever out_valid = 0 (bubble never asserts memory or writeback enables); out_dest/out_alu_res/out_val_rm hold head register contents regardless.
REQ-023 EMPTY + push -> entry into head, ONE.
REQ-024 ONE + push, no pop -> entry into skid, FULL.
REQ-025 ONE + pop, no push -> EMPTY.
REQ-026 ONE + push + pop -> entry into head, stays ONE (throughput 1 entry/cycle).
REQ-027 FULL + pop -> skid moves into head, ONE; push impossible (in_ready = 0).
REQ-028 FULL, no pop -> hold; entries SHALL NOT be overwritten or reordered.
REQ-029 Latency: an entry pushed in cycle N SHALL be visible on outputs with out_valid = 1 in cycle N+1 when the stage was EMPTY, or when ONE with simultaneous pop.
REQ-030 freeze = 1 SHALL hold state, head and skid unchanged; no push or pop occurs.
REQ-031 flush = 1 SHALL set state EMPTY at the next edge, overriding push, pop and freeze; payload registers MAY keep stale data.
REQ-032 Priority: rst > flush > freeze > push/pop.
REQ-033 Entry ordering SHALL be strict FIFO; fields of one entry SHALL never mix with another.

Reset
REQ-034 On rst = 1 at a rising edge: state EMPTY, occupancy 0, head and skid payloads all-zero, out_valid 0, out_ctrl 0, in_ready 1 after release (if freeze = 0).
REQ-035 rst asserted mid-operation (ONE or FULL) SHALL discard all entries identically to REQ-034.

Verification
REQ-036 Reset, then in_valid=1, in_ctrl=3'b001, in_dest=4'hA, in_alu_res=32'h1234, out_ready=1 -> next cycle out_valid=1, out_dest=4'hA, out_alu_res=32'h1234, occupancy stays 1 under continuous streaming.
REQ-037 out_ready=0, push A then B -> occupancy 2, in_ready=0, out shows A; set out_ready=1 -> A then B on consecutive cycles, occupancy 1 then 0.
REQ-038 FULL with freeze=1 and out_ready=1 for 3 cycles -> out_valid=0, out_ctrl=0, in_ready=0, occupancy 2; release freeze -> A, B emerge in order.
REQ-039 FULL, assert flush with in_valid=1 and freeze=1 -> next cycle occupancy 0, out_valid=0, out_ctrl=3'b000, in_ready=1.
REQ-040 Stage ONE holding ctrl=3'b110, assert rst -> next cycle all outputs zero, occupancy 0; random push/pop/freeze/flush run with scoreboard -> no loss, duplication or reordering, out_ctrl=0 whenever out_valid=0.
